ad9361_ensm_sequencer: RTL and testbench

Pin-control ENSM sequencer for one AD9361. It drives the transceiver's ENABLE and TXNRX pins in level mode and enforces the required ordering: TXNRX settles before ENABLE rises, and ENABLE is held low for a minimum time before TXNRX changes. It arbitrates between two requesters: the PS GPIO path (up_enable/up_txnrx) and a TDD scheduler. One instance sits between the system wrapper and the enable/txnrx pads of each transceiver.

---
 rtl/ad9361_ensm_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ad9361_ensm_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_ensm_sequencer.sv
// ad9361_ensm_sequencer
//
// Pin-control ENSM sequencer for one AD9361 in level mode. Decodes a radio
// request from either the GPIO path or the TDD scheduler and sequences the
// ENABLE/TXNRX pins so that TXNRX is settled for a guard window before ENABLE
// rises, and ENABLE stays low for a hold window before TXNRX may change again.
//
// Parameters:
//   GUARD_CYCLES  clocks TXNRX is stable with ENABLE low before ENABLE rises
//   HOLD_CYCLES   clocks ENABLE stays low after falling before TXNRX may change
//   CNT_W         width of the shared guard/hold down-counter
//
// Ports:
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset (released synchronously)
//   src_tdd       1: TDD requester owns the ENSM, 0: GPIO requester owns it
//   sw_enable     GPIO request: radio on
//   sw_txnrx      GPIO request: 1 = TX, 0 = RX
//   tdd_rx_req    TDD request: RX on
//   tdd_tx_req    TDD request: TX on
//   clr_err       clears err_conflict
//   enable        AD9361 ENABLE pin
//   txnrx         AD9361 TXNRX pin
//   rx_active     enable & ~txnrx
//   tx_active     enable & txnrx
//   busy          sequencer not idle
//   state_o       0 = IDLE, 1 = SETUP, 2 = ACTIVE, 3 = RELEASE
//   err_conflict  sticky: TDD requested RX and TX at the same time

module ad9361_ensm_sequencer #(
    parameter int unsigned GUARD_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       src_tdd,
    input  logic       sw_enable,
    input  logic       sw_txnrx,
    input  logic       tdd_rx_req,
    input  logic       tdd_tx_req,
    input  logic       clr_err,
    output logic       enable,
    output logic       txnrx,
    output logic       rx_active,
    output logic       tx_active,
    output logic       busy,
    output logic [1:0] state_o,
    output logic       err_conflict
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSetup   = 2'd1,
        StActive  = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------
    // Reset: assertion reaches every flop immediately, release is aligned
    // to clk. The first edge after resetn rises only releases core_rstn.
    // ------------------------------------------------------------------
    logic core_rstn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_rstn <= 1'b0;
        end else begin
            core_rstn <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Target decode from the current requester inputs. A simultaneous
    // TDD RX+TX request decodes as "off" through the XOR.
    // ------------------------------------------------------------------
    logic tgt_on;
    logic tgt_tx;
    logic tdd_conflict;

    always_comb begin
        tgt_on = sw_enable;
        tgt_tx = sw_txnrx;
        if (src_tdd) begin
            tgt_on = tdd_rx_req ^ tdd_tx_req;
            tgt_tx = tdd_tx_req;
        end
    end

    assign tdd_conflict = src_tdd & tdd_rx_req & tdd_tx_req;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic             enable_q, enable_d;
    logic             txnrx_q, txnrx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q  <= StIdle;
            enable_q <= 1'b0;
            txnrx_q  <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            txnrx_q  <= txnrx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        txnrx_d  = txnrx_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                // txnrx keeps whatever direction was last used.
                if (tgt_on) begin
                    txnrx_d = tgt_tx;
                    cnt_d   = GUARD_LOAD;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (!tgt_on) begin
                    // Abort before ENABLE ever rises.
                    state_d = StIdle;
                end else if (tgt_tx != txnrx_q) begin
                    // Direction changed during the guard: it must be
                    // re-timed from the new TXNRX level.
                    txnrx_d = tgt_tx;
                    cnt_d   = GUARD_LOAD;
                end else if (cnt_q == '0) begin
                    enable_d = 1'b1;
                    state_d  = StActive;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            StActive: begin
                // TXNRX is left untouched here; a new direction is only
                // applied after the hold window and a pass through IDLE.
                if (!tgt_on || (tgt_tx != txnrx_q)) begin
                    enable_d = 1'b0;
                    cnt_d    = HOLD_LOAD;
                    state_d  = StRelease;
                end
            end

            StRelease: begin
                // Requests are ignored until the hold window completes.
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d  = StIdle;
                enable_d = 1'b0;
            end
        endcase
    end

    // Sticky conflict flag; a new conflict wins over a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (tdd_conflict) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign enable       = enable_q;
    assign txnrx        = txnrx_q;
    assign rx_active    = enable_q & ~txnrx_q;
    assign tx_active    = enable_q & txnrx_q;
    assign busy         = (state_q != StIdle);
    assign state_o      = state_q;
    assign err_conflict = err_q;

endmodule

// File: tb/tb_ad9361_ensm_sequencer.sv
// Self-checking bench for ad9361_ensm_sequencer: directed scenarios followed
// by a long randomized run against a timeline-based reference model.

module tb_ad9361_ensm_sequencer;

    localparam int unsigned G = 8;
    localparam int unsigned H = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       src_tdd, sw_enable, sw_txnrx, tdd_rx_req, tdd_tx_req, clr_err;
    logic       enable, txnrx, rx_active, tx_active, busy, err_conflict;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    ad9361_ensm_sequencer #(
        .GUARD_CYCLES(G),
        .HOLD_CYCLES (H),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .src_tdd     (src_tdd),
        .sw_enable   (sw_enable),
        .sw_txnrx    (sw_txnrx),
        .tdd_rx_req  (tdd_rx_req),
        .tdd_tx_req  (tdd_tx_req),
        .clr_err     (clr_err),
        .enable      (enable),
        .txnrx       (txnrx),
        .rx_active   (rx_active),
        .tx_active   (tx_active),
        .busy        (busy),
        .state_o     (state_o),
        .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_tdd    = 1'b0;
        sw_enable  = 1'b0;
        sw_txnrx   = 1'b0;
        tdd_rx_req = 1'b0;
        tdd_tx_req = 1'b0;
        clr_err    = 1'b0;
    endtask

    // Returns just after release; the next edge is the release edge ("edge 0").
    task automatic apply_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        sw_enable = 1'b1;
        resetn    = 1'b0;
        tick();
        tick();
        total++;
        if ({enable, txnrx, rx_active, tx_active, busy, state_o, err_conflict} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {enable, txnrx, rx_active, tx_active, busy, state_o, err_conflict});
        end
        resetn = 1'b1;
        clear_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_rx_bringup();
        apply_reset();
        sw_enable = 1'b1;
        sw_txnrx  = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 1) begin
                total++;
                if (state_o !== 2'd1 || txnrx !== 1'b0) begin
                    bad++;
                    $display("FAIL bringup_setup state=%0d txnrx=%b exp state=1 txnrx=0",
                             state_o, txnrx);
                end
            end
            if (e < 9) begin
                total++;
                if (enable !== 1'b0) begin
                    bad++;
                    $display("FAIL bringup_early_enable edge=%0d got=%b exp=0", e, enable);
                end
            end else begin
                total++;
                if (enable !== 1'b1 || rx_active !== 1'b1 || state_o !== 2'd2) begin
                    bad++;
                    $display("FAIL bringup_active enable=%b rx_active=%b state=%0d exp 1 1 2",
                             enable, rx_active, state_o);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_swap();
        int n;
        n = 0;
        sw_txnrx = 1'b1;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (i == 1) begin
                total++;
                if (enable !== 1'b0) begin
                    bad++;
                    $display("FAIL swap_fall got=%b exp=0", enable);
                end
            end
            if (i <= int'(H)) begin
                total++;
                if (state_o !== 2'd3 || txnrx !== 1'b0) begin
                    bad++;
                    $display("FAIL swap_release i=%0d state=%0d txnrx=%b exp state=3 txnrx=0",
                             i, state_o, txnrx);
                end
            end
            if (i == int'(H) + 1) begin
                total++;
                if (state_o !== 2'd0 || txnrx !== 1'b0) begin
                    bad++;
                    $display("FAIL swap_idle state=%0d txnrx=%b exp state=0 txnrx=0",
                             state_o, txnrx);
                end
            end
            if (i == int'(H) + 2) begin
                total++;
                if (state_o !== 2'd1 || txnrx !== 1'b1) begin
                    bad++;
                    $display("FAIL swap_setup state=%0d txnrx=%b exp state=1 txnrx=1",
                             state_o, txnrx);
                end
            end
            if (enable === 1'b1) n = i;
        end
        total++;
        if (n != int'(H + G + 2)) begin
            bad++;
            $display("FAIL swap_turnaround edges=%0d exp=%0d", n, H + G + 2);
        end
        total++;
        if (tx_active !== 1'b1) begin
            bad++;
            $display("FAIL swap_tx_active got=%b exp=1", tx_active);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        // Still ACTIVE TX from the swap scenario.
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        total++;
        if (enable !== 1'b0 || txnrx !== 1'b0 || state_o !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset enable=%b txnrx=%b state=%0d busy=%b exp all 0",
                     enable, txnrx, state_o, busy);
        end
        clear_inputs();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort();
        logic saw_setup;
        saw_setup = 1'b0;
        apply_reset();
        tick();
        sw_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) sw_enable = 1'b0;
            if (state_o === 2'd1) saw_setup = 1'b1;
            total++;
            if (enable !== 1'b0) begin
                bad++;
                $display("FAIL abort_enable i=%0d got=%b exp=0", i, enable);
            end
        end
        total++;
        if (saw_setup !== 1'b1 || busy !== 1'b0 || state_o !== 2'd0) begin
            bad++;
            $display("FAIL abort_end saw_setup=%b busy=%b state=%0d exp 1 0 0",
                     saw_setup, busy, state_o);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_conflict();
        apply_reset();
        tick();
        total++;
        if (err_conflict !== 1'b0) begin
            bad++;
            $display("FAIL conflict_init got=%b exp=0", err_conflict);
        end
        src_tdd    = 1'b1;
        tdd_rx_req = 1'b1;
        tdd_tx_req = 1'b1;
        clr_err    = 1'b1;
        tick();
        total++;
        if (err_conflict !== 1'b1 || enable !== 1'b0 || state_o !== 2'd0) begin
            bad++;
            $display("FAIL conflict_set err=%b enable=%b state=%0d exp 1 0 0",
                     err_conflict, enable, state_o);
        end
        clr_err = 1'b0;
        tick();
        tick();
        total++;
        if (err_conflict !== 1'b1 || enable !== 1'b0) begin
            bad++;
            $display("FAIL conflict_sticky err=%b enable=%b exp 1 0", err_conflict, enable);
        end
        tdd_rx_req = 1'b0;
        tdd_tx_req = 1'b0;
        clr_err    = 1'b1;
        tick();
        clr_err = 1'b0;
        total++;
        if (err_conflict !== 1'b0) begin
            bad++;
            $display("FAIL conflict_clear got=%b exp=0", err_conflict);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_restart();
        int n;
        n = 0;
        apply_reset();
        tick();
        sw_enable = 1'b1;
        sw_txnrx  = 1'b0;
        // Five edges in SETUP leave the guard counter at 3.
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (state_o !== 2'd1 || enable !== 1'b0) begin
                bad++;
                $display("FAIL restart_pre i=%0d state=%0d enable=%b exp 1 0",
                         i, state_o, enable);
            end
        end
        sw_txnrx = 1'b1;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            tick();
            if (enable === 1'b1) n = i;
            total++;
            if (txnrx !== 1'b1) begin
                bad++;
                $display("FAIL restart_txnrx i=%0d got=%b exp=1", i, txnrx);
            end
        end
        total++;
        if (n != int'(G) + 1) begin
            bad++;
            $display("FAIL restart_delay edges=%0d exp=%0d", n, G + 1);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase plus time spent in it, advanced once per edge.
    int   m_phase;
    int   m_time;
    logic m_en, m_tx, m_err;

    task automatic model_step();
        logic on, tx;
        if (src_tdd) begin
            on = (tdd_rx_req != tdd_tx_req);
            tx = tdd_tx_req;
        end else begin
            on = sw_enable;
            tx = sw_txnrx;
        end
        if (src_tdd && tdd_rx_req && tdd_tx_req) m_err = 1'b1;
        else if (clr_err)                        m_err = 1'b0;

        if (m_phase == 0) begin
            if (on) begin
                m_tx = tx; m_phase = 1; m_time = 1;
            end
        end else if (m_phase == 1) begin
            if (!on) m_phase = 0;
            else if (tx != m_tx) begin
                m_tx = tx; m_time = 1;
            end else if (m_time == int'(G)) begin
                m_en = 1'b1; m_phase = 2;
            end else m_time++;
        end else if (m_phase == 2) begin
            if (!on || tx != m_tx) begin
                m_en = 1'b0; m_phase = 3; m_time = 1;
            end
        end else begin
            if (m_time == int'(H)) m_phase = 0;
            else m_time++;
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_v, got_v;
        logic       prev_en, prev_tx;
        int         errs;
        errs = 0;
        apply_reset();
        tick();
        m_phase = 0; m_time = 0; m_en = 1'b0; m_tx = 1'b0; m_err = 1'b0;
        prev_en = 1'b0;
        prev_tx = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 23))
                0: src_tdd    = ~src_tdd;
                1: sw_enable  = ~sw_enable;
                2: sw_txnrx   = ~sw_txnrx;
                3: tdd_rx_req = ~tdd_rx_req;
                4: tdd_tx_req = ~tdd_tx_req;
                default: ;
            endcase
            clr_err = ($urandom_range(0, 15) == 0);
            model_step();
            tick();
            exp_v = {m_en, m_tx, m_en & ~m_tx, m_en & m_tx, m_phase != 0,
                     2'(m_phase), m_err};
            got_v = {enable, txnrx, rx_active, tx_active, busy, state_o, err_conflict};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle c=%0d got=%b exp=%b", c, got_v, exp_v);
            end
            if (prev_en || enable) begin
                total++;
                if (txnrx !== prev_tx) begin
                    bad++;
                    $display("FAIL txnrx_invariant c=%0d got=%b exp=%b", c, txnrx, prev_tx);
                end
            end
            prev_en = enable;
            prev_tx = txnrx;
        end
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    initial begin
        clear_inputs();
        resetn = 1'b0;
        test_reset();
        test_rx_bringup();
        test_swap();
        test_async_reset();
        test_abort();
        test_conflict();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
